// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
//   Decode-to-execute pipeline register. Captures the register file operands
//   together with the decoded control word and presents one registered
//   instruction per cycle to EX. Detects load-use hazards and inserts one
//   bubble for each, honours branch flush, and counts stall cycles with a
//   saturating counter.
//
// Optional feature (macro ID_EX_WB_BYPASS_EN):
//   Adds wb_en / wb_addr / wb_data. A write-back to the dst or src address
//   in the same cycle replaces the captured operand value. This is for
//   register files without write-through. Hazard detection does not change.
//
// Ports
//   clk, reset                  clock, synchronous active-high reset
//   in_valid / in_ready         decode -> stage handshake
//   in_op, src_addr, dst_addr   decoded instruction fields
//   use_src, use_dst            operand usage flags (hazard qualification)
//   read_data1 / read_data2     regfile data at dst_addr / src_addr
//   in_imm, in_mem_read, in_reg_write   immediate and control
//   flush                       branch taken: kill held and incoming instr
//   ex_ready / ex_valid         stage -> EX handshake
//   ex_op .. ex_reg_write       registered instruction
//   stall_cnt                   load-use stall cycles, saturating
//
// Handshake: an input transfer occurs on a posedge where in_valid & in_ready
// and no flush. The output is consumed on a posedge where ex_valid & ex_ready.
// in_ready is combinational and can be high during flush, because a flush
// consumes the incoming instruction and discards it.
// ---------------------------------------------------------------------------
module id_ex_stage #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3,
    parameter int OP_W   = 5,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_op,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic              use_src,
    input  logic              use_dst,
    input  logic [DATA_W-1:0] read_data1,
    input  logic [DATA_W-1:0] read_data2,
    input  logic [DATA_W-1:0] in_imm,
    input  logic              in_mem_read,
    input  logic              in_reg_write,
    input  logic              flush,
    input  logic              ex_ready,
    output logic              ex_valid,
    output logic [OP_W-1:0]   ex_op,
    output logic [DATA_W-1:0] ex_op1,
    output logic [DATA_W-1:0] ex_op2,
    output logic [DATA_W-1:0] ex_imm,
    output logic [ADDR_W-1:0] ex_dst,
    output logic              ex_mem_read,
    output logic              ex_reg_write,
    output logic [CNT_W-1:0]  stall_cnt
`ifdef ID_EX_WB_BYPASS_EN
    ,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data
`endif
);

    localparam logic [CNT_W-1:0] CNT_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              ex_valid_q,     ex_valid_d;
    logic [OP_W-1:0]   ex_op_q,        ex_op_d;
    logic [DATA_W-1:0] ex_op1_q,       ex_op1_d;
    logic [DATA_W-1:0] ex_op2_q,       ex_op2_d;
    logic [DATA_W-1:0] ex_imm_q,       ex_imm_d;
    logic [ADDR_W-1:0] ex_dst_q,       ex_dst_d;
    logic              ex_mem_read_q,  ex_mem_read_d;
    logic              ex_reg_write_q, ex_reg_write_d;
    logic [CNT_W-1:0]  stall_cnt_q,    stall_cnt_d;

    logic              hazard;
    logic [DATA_W-1:0] op1_sel;
    logic [DATA_W-1:0] op2_sel;

    // Load-use hazard: the load in EX has no data until after EX. So a
    // dependent instruction waits one cycle behind a bubble.
    always_comb begin
        hazard = in_valid & ex_valid_q & ex_mem_read_q & ex_reg_write_q &
                 ((use_src & (ex_dst_q == src_addr)) |
                  (use_dst & (ex_dst_q == dst_addr)));
        in_ready = flush | (~hazard & (~ex_valid_q | ex_ready));
    end

    // Operand selection at capture time.
    always_comb begin
        op1_sel = read_data1;
        op2_sel = read_data2;
`ifdef ID_EX_WB_BYPASS_EN
        if (wb_en && (wb_addr == dst_addr)) op1_sel = wb_data;
        if (wb_en && (wb_addr == src_addr)) op2_sel = wb_data;
`endif
    end

    // Next-state. Priority: flush > hazard > advance > drain > hold.
    always_comb begin
        ex_valid_d     = ex_valid_q;
        ex_op_d        = ex_op_q;
        ex_op1_d       = ex_op1_q;
        ex_op2_d       = ex_op2_q;
        ex_imm_d       = ex_imm_q;
        ex_dst_d       = ex_dst_q;
        ex_mem_read_d  = ex_mem_read_q;
        ex_reg_write_d = ex_reg_write_q;
        stall_cnt_d    = stall_cnt_q;

        if (flush) begin
            ex_valid_d     = 1'b0;
            ex_mem_read_d  = 1'b0;
            ex_reg_write_d = 1'b0;
        end else if (hazard) begin
            // If EX takes the load, replace it with a bubble. Otherwise hold the load.
            if (ex_ready) begin
                ex_valid_d     = 1'b0;
                ex_mem_read_d  = 1'b0;
                ex_reg_write_d = 1'b0;
            end
        end else if (in_valid && in_ready) begin
            ex_valid_d     = 1'b1;
            ex_op_d        = in_op;
            ex_op1_d       = op1_sel;
            ex_op2_d       = op2_sel;
            ex_imm_d       = in_imm;
            ex_dst_d       = dst_addr;
            ex_mem_read_d  = in_mem_read;
            ex_reg_write_d = in_reg_write;
        end else if (ex_ready) begin
            ex_valid_d = 1'b0;
        end

        if (hazard && !flush && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid_q     <= 1'b0;
            ex_op_q        <= '0;
            ex_op1_q       <= '0;
            ex_op2_q       <= '0;
            ex_imm_q       <= '0;
            ex_dst_q       <= '0;
            ex_mem_read_q  <= 1'b0;
            ex_reg_write_q <= 1'b0;
            stall_cnt_q    <= '0;
        end else begin
            ex_valid_q     <= ex_valid_d;
            ex_op_q        <= ex_op_d;
            ex_op1_q       <= ex_op1_d;
            ex_op2_q       <= ex_op2_d;
            ex_imm_q       <= ex_imm_d;
            ex_dst_q       <= ex_dst_d;
            ex_mem_read_q  <= ex_mem_read_d;
            ex_reg_write_q <= ex_reg_write_d;
            stall_cnt_q    <= stall_cnt_d;
        end
    end

    assign ex_valid     = ex_valid_q;
    assign ex_op        = ex_op_q;
    assign ex_op1       = ex_op1_q;
    assign ex_op2       = ex_op2_q;
    assign ex_imm       = ex_imm_q;
    assign ex_dst       = ex_dst_q;
    assign ex_mem_read  = ex_mem_read_q;
    assign ex_reg_write = ex_reg_write_q;
    assign stall_cnt    = stall_cnt_q;

endmodule
